axi_burst_sram: RTL and testbench
=================================

AXI_BURST_SRAM -- requirements
Module: axi_burst_sram

Interface
REQ-001 SHALL have parameter DATA_W, default 64: data bus width in bits; power of two, 32..256.
REQ-002 SHALL have parameter ADDR_W, default 32: byte address width.
REQ-003 SHALL have parameter ID_W, default 4: AXI ID width.
REQ-004 SHALL have parameter DEPTH, default 4096: memory size in DATA_W words.
REQ-005 SHALL have parameter RD_LAT, default 1: cycles from AR handshake to first rvalid; range 1..8.
REQ-006 SHALL have one clock, aclk (input, 1): all logic on its rising edge.
REQ-007 SHALL have reset areset (input, 1): synchronous, active-high.
REQ-008 SHALL have the AW channel, in: awid ID_W, awaddr ADDR_W, awlen 8, awburst 2, awvalid 1; out: awready 1.
REQ-009 SHALL have the W channel, in: wdata DATA_W, wstrb DATA_W/8, wlast 1, wvalid 1; out: wready 1.
REQ-010 SHALL have the B channel, out: bid ID_W, bresp 2, bvalid 1; in: bready 1.
REQ-011 SHALL have the AR channel, in: arid ID_W, araddr ADDR_W, arlen 8, arburst 2, arvalid 1; out: arready 1.
REQ-012 SHALL have the R channel, out: rid ID_W, rdata DATA_W, rresp 2, rlast 1, rvalid 1; in: rready 1.

Function
REQ-013 SHALL implement every beat as full width; word index = addr >> log2(DATA_W/8), and low byte-offset bits are ignored.
REQ-014 SHALL run a write FSM W_IDLE -> W_DATA (on AW handshake) -> W_RESP (on W handshake of beat awlen) -> W_IDLE (on B handshake).
REQ-015 SHALL drive awready=1 only in W_IDLE, wready=1 only in W_DATA, and bvalid=1 only in W_RESP.
REQ-016 SHALL write each W beat on its handshake cycle, updating only the bytes whose wstrb bit is 1.
REQ-017 SHALL run a read FSM R_IDLE -> R_WAIT (RD_LAT-1 cycles; skipped when RD_LAT=1) -> R_DATA -> R_IDLE (on handshake of beat arlen with rlast=1).
REQ-018 SHALL drive arready=1 only in R_IDLE, assert rvalid exactly RD_LAT cycles after the AR handshake, and hold rdata/rlast/rresp stable while rvalid=1 and rready=0.
REQ-019 SHALL accept one outstanding transaction per direction, with the read and write paths fully independent.
REQ-020 SHALL generate addresses per burst: FIXED (00) repeats the same word; INCR (01) adds one word per beat; WRAP (10) wraps at a (len+1)*DATA_W/8 byte-aligned boundary.
REQ-021 SHALL return SLVERR (10) for burst 11, or WRAP with len not in {1,3,7,15}; such writes are suppressed and such reads return 0, with the full beat count still transferred.
REQ-022 SHALL return DECERR (11) for any beat whose word index is >= DEPTH; that beat is not written, or is read as 0; the response is the worst seen over the burst.
REQ-023 SHALL ignore wlast for beat counting; if wlast mismatches the final-beat position, bresp SHALL be SLVERR, unless a DECERR has already occurred.
REQ-024 SHALL return the pre-write (old) data when a read and a write hit the same word in the same cycle.
REQ-025 SHALL echo bid=awid and rid=arid as latched at the address handshake.

Reset
REQ-026 SHALL, while areset=1, drive awready, wready, bvalid, arready, rvalid and rlast to 0; bresp, rresp, bid, rid and rdata to 0; and both FSMs to IDLE.
REQ-027 SHALL abandon any in-flight burst on reset without a B or R response; memory contents are not cleared.
REQ-028 SHALL assert awready and arready on the first cycle after areset deasserts.

Structure
REQ-029 SHALL place burst encodings, response codes (OKAY, SLVERR, DECERR) and FSM state enums in shared package axi_sram_pkg.
REQ-030 SHALL compute next addresses, including wrap-mask logic, in sub-module axi_burst_addr_gen, instantiated once per direction.

Verification
REQ-031 SHALL cover: INCR write, len=3, addr 0x100, wstrb 0xFF, data 1..4, then read -> bresp 00; rdata 1,2,3,4; rlast on beat 4 only.
REQ-032 SHALL cover: WRAP read, len=3, araddr 0x118 (DATA_W=64) -> word order 0x118, 0x100, 0x108, 0x110; rresp 00.
REQ-033 SHALL cover: write with wstrb 0x0F over existing 0xFFFF_FFFF_FFFF_FFFF using data 0 -> word reads back 0xFFFF_FFFF_0000_0000.
REQ-034 SHALL cover: read at word DEPTH -> rresp 11, rdata 0; and arburst 11 -> rresp 10 on every beat.
REQ-035 SHALL cover: RD_LAT=3 with rready held low for 5 cycles -> rvalid rises exactly 3 cycles after AR handshake and rdata stays stable until the handshake.
REQ-036 SHALL cover: areset pulsed mid write burst (after beat 2 of 4) -> bvalid never asserted, and awready=1 on the cycle after reset.

Source files
------------

// File: rtl/axi_sram_pkg.sv
// Shared definitions for the AXI burst SRAM.
// Contents: burst encodings, response codes, read/write FSM state enums,
// and small helpers for burst legality and response merging.
package axi_sram_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } r_state_e;

  // Reserved burst type, or a WRAP whose length is not 2/4/8/16 beats.
  function automatic logic burst_illegal(input logic [1:0] burst, input logic [7:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

  // Encodings are ordered so that the numerically larger code is the worse one.
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address calculator for one AXI burst.
// Ports:
//   addr_i      - address of the current beat
//   burst_i     - burst type (FIXED / INCR / WRAP)
//   len_i       - AXI length field (beats - 1)
//   next_addr_o - address of the following beat
module axi_burst_addr_gen
  import axi_sram_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int BYTES  = 8
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        burst_i,
  input  logic [7:0]        len_i,
  output logic [ADDR_W-1:0] next_addr_o
);

  localparam int OFF_W = $clog2(BYTES);

  logic [ADDR_W-1:0] step_addr;
  logic [ADDR_W-1:0] wrap_mask;

  always_comb begin
    step_addr = addr_i + ADDR_W'(BYTES);
    // Wrap window is (len+1) beats; the mask selects the offset within it.
    wrap_mask = ((ADDR_W'(len_i) + ADDR_W'(1)) << OFF_W) - ADDR_W'(1);
    case (burst_i)
      BURST_INCR: next_addr_o = step_addr;
      BURST_WRAP: next_addr_o = (addr_i & ~wrap_mask) | (step_addr & wrap_mask);
      default:    next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi_burst_sram.sv
// AXI4 burst slave backed by a single inferred block RAM.
// Ports:
//   aclk, areset            - clock and synchronous active-high reset
//   aw*/w*/b*               - write address, data and response channels
//   ar*/r*                  - read address and data channels
// One outstanding burst per direction; read and write paths are independent
// and share only the memory array (read-during-write returns old data).
module axi_burst_sram
  import axi_sram_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 1
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  // R_WAIT lasts RD_LAT-1 cycles; the counter runs down to zero.
  localparam logic [2:0] WAIT_INIT = 3'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return (a >> OFF_W) >= DEPTH_A;
  endfunction

  // ---------------- memory ----------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_rdata_q;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [IDX_W-1:0]  mem_ridx;

  // ---------------- write path ----------------
  w_state_e          w_state_q;
  logic              awready_q, wready_q, bvalid_q;
  logic [ID_W-1:0]   bid_q;
  logic [1:0]        bresp_q;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_len_q, wr_cnt_q;
  logic [1:0]        wr_burst_q;
  logic              wr_err_q, wr_last_bad_q;
  logic [1:0]        wr_resp_q, wr_resp_d, wr_beat_resp, wr_final;
  logic              w_hs, wr_oob, wr_is_last, wr_last_mis;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W), .BYTES(BYTES)) u_wr_addr (
    .addr_i      (wr_addr_q),
    .burst_i     (wr_burst_q),
    .len_i       (wr_len_q),
    .next_addr_o (wr_addr_d)
  );

  always_comb begin
    w_hs         = wvalid && wready_q;
    wr_oob       = out_of_range(wr_addr_q);
    wr_is_last   = (wr_cnt_q == wr_len_q);
    wr_last_mis  = (wlast != wr_is_last);
    mem_we       = w_hs && !wr_err_q && !wr_oob;
    mem_widx     = wr_addr_q[OFF_W +: IDX_W];
    wr_beat_resp = wr_err_q ? RESP_SLVERR : (wr_oob ? RESP_DECERR : RESP_OKAY);
    wr_resp_d    = resp_worst(wr_resp_q, wr_beat_resp);
    // A wlast mismatch downgrades to SLVERR but never masks a DECERR.
    wr_final     = resp_worst(wr_resp_d,
                              (wr_last_bad_q || wr_last_mis) ? RESP_SLVERR : RESP_OKAY);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q     <= W_IDLE;
      awready_q     <= 1'b0;
      wready_q      <= 1'b0;
      bvalid_q      <= 1'b0;
      bid_q         <= '0;
      bresp_q       <= RESP_OKAY;
      wr_addr_q     <= '0;
      wr_len_q      <= '0;
      wr_cnt_q      <= '0;
      wr_burst_q    <= BURST_FIXED;
      wr_err_q      <= 1'b0;
      wr_last_bad_q <= 1'b0;
      wr_resp_q     <= RESP_OKAY;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (awvalid && awready_q) begin
            awready_q     <= 1'b0;
            wready_q      <= 1'b1;
            w_state_q     <= W_DATA;
            bid_q         <= awid;
            wr_addr_q     <= awaddr;
            wr_len_q      <= awlen;
            wr_burst_q    <= awburst;
            wr_err_q      <= burst_illegal(awburst, awlen);
            wr_cnt_q      <= '0;
            wr_resp_q     <= RESP_OKAY;
            wr_last_bad_q <= 1'b0;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            wr_addr_q     <= wr_addr_d;
            wr_cnt_q      <= wr_cnt_q + 8'd1;
            wr_resp_q     <= wr_resp_d;
            wr_last_bad_q <= wr_last_bad_q || wr_last_mis;
            if (wr_is_last) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= wr_final;
              w_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  r_state_e          r_state_q;
  logic              arready_q, rvalid_q, rlast_q, rd_zero_q;
  logic [ID_W-1:0]   rid_q;
  logic [1:0]        rresp_q;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        rd_len_q, rd_cnt_q;
  logic [1:0]        rd_burst_q;
  logic              rd_err_q;
  logic [2:0]        rd_wait_q;
  logic              ar_hs, r_hs;
  logic              rd_load, rd_load_err;
  logic [ADDR_W-1:0] rd_load_addr;
  logic [1:0]        rd_load_resp;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W), .BYTES(BYTES)) u_rd_addr (
    .addr_i      (rd_addr_q),
    .burst_i     (rd_burst_q),
    .len_i       (rd_len_q),
    .next_addr_o (rd_addr_d)
  );

  // The RAM is read one cycle before each beat is presented: on the AR
  // handshake (RD_LAT=1), at the end of the wait, or on a non-final R handshake.
  always_comb begin
    ar_hs        = arvalid && arready_q;
    r_hs         = rvalid_q && rready;
    rd_load      = 1'b0;
    rd_load_addr = rd_addr_q;
    rd_load_err  = rd_err_q;
    if (ar_hs && (RD_LAT == 1)) begin
      rd_load      = 1'b1;
      rd_load_addr = araddr;
      rd_load_err  = burst_illegal(arburst, arlen);
    end else if ((r_state_q == R_WAIT) && (rd_wait_q == 3'd0)) begin
      rd_load = 1'b1;
    end else if ((r_state_q == R_DATA) && r_hs && !rlast_q) begin
      rd_load      = 1'b1;
      rd_load_addr = rd_addr_d;
    end
    rd_load_resp = rd_load_err ? RESP_SLVERR
                 : (out_of_range(rd_load_addr) ? RESP_DECERR : RESP_OKAY);
    mem_ridx     = rd_load_addr[OFF_W +: IDX_W];
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state_q  <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rid_q      <= '0;
      rd_zero_q  <= 1'b1;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_cnt_q   <= '0;
      rd_burst_q <= BURST_FIXED;
      rd_err_q   <= 1'b0;
      rd_wait_q  <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            arready_q  <= 1'b0;
            rid_q      <= arid;
            rd_addr_q  <= araddr;
            rd_len_q   <= arlen;
            rd_burst_q <= arburst;
            rd_err_q   <= burst_illegal(arburst, arlen);
            rd_cnt_q   <= '0;
            rd_wait_q  <= WAIT_INIT;
            if (RD_LAT == 1) begin
              r_state_q <= R_DATA;
              rvalid_q  <= 1'b1;
              rlast_q   <= (arlen == 8'd0);
              rresp_q   <= rd_load_resp;
              rd_zero_q <= (rd_load_resp != RESP_OKAY);
            end else begin
              r_state_q <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (rd_wait_q == 3'd0) begin
            r_state_q <= R_DATA;
            rvalid_q  <= 1'b1;
            rlast_q   <= (rd_len_q == 8'd0);
            rresp_q   <= rd_load_resp;
            rd_zero_q <= (rd_load_resp != RESP_OKAY);
          end else begin
            rd_wait_q <= rd_wait_q - 3'd1;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              r_state_q <= R_IDLE;
            end else begin
              rd_addr_q <= rd_addr_d;
              rd_cnt_q  <= rd_cnt_q + 8'd1;
              rlast_q   <= ((rd_cnt_q + 8'd1) == rd_len_q);
              rresp_q   <= rd_load_resp;
              rd_zero_q <= (rd_load_resp != RESP_OKAY);
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // Memory is deliberately not reset. Both ports sit in one block so that a
  // same-cycle read of a word being written captures the old contents.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) mem_q[mem_widx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (rd_load) mem_rdata_q <= mem_q[mem_ridx];
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rresp   = rresp_q;
  assign rid     = rid_q;
  // Error beats and the reset state present zero data.
  assign rdata   = rd_zero_q ? '0 : mem_rdata_q;

endmodule

// File: tb/tb_axi_burst_sram.sv
module tb_axi_burst_sram;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int IW = 4;
  localparam int DP = 4096;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  logic [IW-1:0] awid;   logic [AW-1:0] awaddr; logic [7:0] awlen; logic [1:0] awburst;
  logic          awvalid;
  logic [DW-1:0] wdata;  logic [7:0] wstrb;     logic wlast;       logic wvalid;
  logic          bready;
  logic [IW-1:0] arid;   logic [AW-1:0] araddr; logic [7:0] arlen; logic [1:0] arburst;
  logic          arvalid_in, rready, rsel;
  logic          arvalid0, arvalid1;
  assign arvalid0 = arvalid_in & ~rsel;
  assign arvalid1 = arvalid_in & rsel;

  logic          awready0, wready0, bvalid0, arready0, rvalid0, rlast0;
  logic [IW-1:0] bid0, rid0;  logic [1:0] bresp0, rresp0; logic [DW-1:0] rdata0;
  logic          awready1, wready1, bvalid1, arready1, rvalid1, rlast1;
  logic [IW-1:0] bid1, rid1;  logic [1:0] bresp1, rresp1; logic [DW-1:0] rdata1;

  axi_burst_sram #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IW), .DEPTH(DP), .RD_LAT(1)) dut0 (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready0),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready0),
    .bid(bid0), .bresp(bresp0), .bvalid(bvalid0), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid0), .arready(arready0),
    .rid(rid0), .rdata(rdata0), .rresp(rresp0), .rlast(rlast0), .rvalid(rvalid0), .rready(rready)
  );

  axi_burst_sram #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IW), .DEPTH(DP), .RD_LAT(3)) dut1 (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready1),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready1),
    .bid(bid1), .bresp(bresp1), .bvalid(bvalid1), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid1), .arready(arready1),
    .rid(rid1), .rdata(rdata1), .rresp(rresp1), .rlast(rlast1), .rvalid(rvalid1), .rready(rready)
  );

  // Read-side view of whichever instance rsel selects.
  logic          m_arready, m_rvalid, m_rlast;
  logic [1:0]    m_rresp;
  logic [DW-1:0] m_rdata;
  logic [IW-1:0] m_rid;
  always_comb begin
    m_arready = rsel ? arready1 : arready0;
    m_rvalid  = rsel ? rvalid1  : rvalid0;
    m_rlast   = rsel ? rlast1   : rlast0;
    m_rresp   = rsel ? rresp1   : rresp0;
    m_rdata   = rsel ? rdata1   : rdata0;
    m_rid     = rsel ? rid1     : rid0;
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] rd_d [16];
  logic [1:0]    rd_r [16];
  logic          rd_l [16];
  logic [IW-1:0] rd_id;
  int            rd_lat;

  task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [DW-1:0] base, input logic [7:0] strb,
                          input int last_at, output logic [1:0] resp, output logic [IW-1:0] rbid);
    int n;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready0 && n < 50) begin @(posedge aclk); #1; n++; end
    if (!awready0) begin n_checks++; $display("FAIL aw_timeout awready=%0b required=1", awready0); end
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = base + 64'(i); wstrb = strb; wlast = (i == last_at); wvalid = 1'b1;
      n = 0;
      while (!wready0 && n < 50) begin @(posedge aclk); #1; n++; end
      if (!wready0) begin n_checks++; $display("FAIL w_timeout beat=%0d wready=0 required=1", i); end
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid0 && n < 50) begin @(posedge aclk); #1; n++; end
    if (!bvalid0) begin n_checks++; $display("FAIL b_timeout bvalid=0 required=1"); end
    resp = bresp0; rbid = bid0;
    @(posedge aclk); #1;
    bready = 1'b0;
    $display("write id=%0d addr=0x%0h len=%0d burst=%0d bresp=%0d bid=%0d", id, addr, len, burst, resp, rbid);
  endtask

  task automatic do_read(input logic sel, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n;
    rsel = sel; arid = id; araddr = addr; arlen = len; arburst = burst; arvalid_in = 1'b1; rready = 1'b1;
    n = 0;
    while (!m_arready && n < 50) begin @(posedge aclk); #1; n++; end
    if (!m_arready) begin n_checks++; $display("FAIL ar_timeout arready=0 required=1"); end
    @(posedge aclk); #1;
    arvalid_in = 1'b0;
    rd_lat = 1;
    while (!m_rvalid && rd_lat < 20) begin @(posedge aclk); #1; rd_lat++; end
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!m_rvalid && n < 50) begin @(posedge aclk); #1; n++; end
      if (!m_rvalid) begin n_checks++; $display("FAIL r_timeout beat=%0d rvalid=0 required=1", i); end
      rd_d[i] = m_rdata; rd_r[i] = m_rresp; rd_l[i] = m_rlast; rd_id = m_rid;
      @(posedge aclk); #1;
    end
    $display("read dut=%0d id=%0d addr=0x%0h len=%0d burst=%0d lat=%0d rresp0=%0d rdata0=0x%0h",
             sel, id, addr, len, burst, rd_lat, rd_r[0], rd_d[0]);
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    n_checks++;
    if ({awready0, wready0, bvalid0, arready0, rvalid0, rlast0} !== 6'b0)
      $display("FAIL reset_ctrl got=%b required=000000", {awready0, wready0, bvalid0, arready0, rvalid0, rlast0});
    else n_pass++;
    n_checks++;
    if ({bresp0, rresp0, bid0, rid0, rdata0} !== 76'd0)
      $display("FAIL reset_data bresp=%0h rresp=%0h bid=%0h rid=%0h rdata=%0h required=0", bresp0, rresp0, bid0, rid0, rdata0);
    else n_pass++;
    n_checks++;
    if ({arready1, rvalid1, rdata1} !== 66'd0)
      $display("FAIL reset_lat3 arready=%0b rvalid=%0b rdata=%0h required=0", arready1, rvalid1, rdata1);
    else n_pass++;
    areset = 1'b0;
    @(posedge aclk); #1;
    n_checks++;
    if ({awready0, arready0, arready1} !== 3'b111)
      $display("FAIL reset_release got=%b required=111", {awready0, arready0, arready1});
    else n_pass++;
    $display("reset done");
  endtask

  task automatic test_incr();
    logic [1:0] resp; logic [IW-1:0] b;
    do_write(4'd3, 32'h100, 8'd3, 2'b01, 64'd1, 8'hFF, 3, resp, b);
    n_checks++;
    if ({resp, b} !== {2'b00, 4'd3}) $display("FAIL incr_bresp got=%0h/%0h required=0/3", resp, b); else n_pass++;
    do_read(1'b0, 4'd5, 32'h100, 8'd3, 2'b01);
    n_checks++;
    if (rd_lat !== 1) $display("FAIL incr_lat1 got=%0d required=1", rd_lat); else n_pass++;
    n_checks++;
    if (rd_id !== 4'd5) $display("FAIL incr_rid got=%0d required=5", rd_id); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({rd_d[i], rd_r[i], rd_l[i]} !== {64'(i + 1), 2'b00, (i == 3)})
        $display("FAIL incr_beat%0d data=%0h resp=%0h last=%0b required=%0h/0/%0b", i, rd_d[i], rd_r[i], rd_l[i], i + 1, (i == 3));
      else n_pass++;
    end
    do_read(1'b1, 4'd6, 32'h100, 8'd3, 2'b01);
    n_checks++;
    if (rd_lat !== 3) $display("FAIL incr_lat3 got=%0d required=3", rd_lat); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({rd_d[i], rd_l[i]} !== {64'(i + 1), (i == 3)})
        $display("FAIL incr3_beat%0d data=%0h last=%0b required=%0h/%0b", i, rd_d[i], rd_l[i], i + 1, (i == 3));
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] exp_w [4];
    exp_w = '{64'd4, 64'd1, 64'd2, 64'd3};
    do_read(1'b0, 4'd2, 32'h118, 8'd3, 2'b10);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({rd_d[i], rd_r[i], rd_l[i]} !== {exp_w[i], 2'b00, (i == 3)})
        $display("FAIL wrap_beat%0d data=%0h resp=%0h last=%0b required=%0h/0/%0b", i, rd_d[i], rd_r[i], rd_l[i], exp_w[i], (i == 3));
      else n_pass++;
    end
    do_read(1'b0, 4'd1, 32'h108, 8'd2, 2'b00);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({rd_d[i], rd_r[i]} !== {64'd2, 2'b00})
        $display("FAIL fixed_beat%0d data=%0h resp=%0h required=2/0", i, rd_d[i], rd_r[i]);
      else n_pass++;
    end
  endtask

  task automatic test_strobe();
    logic [1:0] r1, r2; logic [IW-1:0] b;
    do_write(4'd1, 32'h200, 8'd0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, r1, b);
    do_write(4'd1, 32'h200, 8'd0, 2'b01, 64'd0, 8'h0F, 0, r2, b);
    n_checks++;
    if ({r1, r2} !== 4'b0) $display("FAIL strobe_bresp got=%0h/%0h required=0/0", r1, r2); else n_pass++;
    do_read(1'b0, 4'd1, 32'h200, 8'd0, 2'b01);
    n_checks++;
    if (rd_d[0] !== 64'hFFFF_FFFF_0000_0000)
      $display("FAIL strobe_data got=%0h required=ffffffff00000000", rd_d[0]);
    else n_pass++;
  endtask

  task automatic test_errors();
    logic [1:0] resp; logic [IW-1:0] b;
    do_read(1'b0, 4'd7, 32'h8000, 8'd0, 2'b01);
    n_checks++;
    if ({rd_d[0], rd_r[0], rd_l[0]} !== {64'd0, 2'b11, 1'b1})
      $display("FAIL oob_read data=%0h resp=%0h last=%0b required=0/3/1", rd_d[0], rd_r[0], rd_l[0]);
    else n_pass++;
    do_read(1'b0, 4'd7, 32'h100, 8'd3, 2'b11);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({rd_d[i], rd_r[i]} !== {64'd0, 2'b10})
        $display("FAIL rsvd_beat%0d data=%0h resp=%0h required=0/2", i, rd_d[i], rd_r[i]);
      else n_pass++;
    end
    do_write(4'd2, 32'h7FF8, 8'd1, 2'b01, 64'hA0, 8'hFF, 1, resp, b);
    n_checks++;
    if (resp !== 2'b11) $display("FAIL edge_write_bresp got=%0h required=3", resp); else n_pass++;
    do_read(1'b0, 4'd2, 32'h7FF8, 8'd1, 2'b01);
    n_checks++;
    if ({rd_d[0], rd_r[0], rd_d[1], rd_r[1]} !== {64'hA0, 2'b00, 64'd0, 2'b11})
      $display("FAIL edge_read d0=%0h r0=%0h d1=%0h r1=%0h required=a0/0/0/3", rd_d[0], rd_r[0], rd_d[1], rd_r[1]);
    else n_pass++;
    do_write(4'd2, 32'h8000, 8'd0, 2'b01, 64'h5, 8'hFF, 0, resp, b);
    n_checks++;
    if (resp !== 2'b11) $display("FAIL oob_write_bresp got=%0h required=3", resp); else n_pass++;
    do_write(4'd9, 32'h100, 8'd2, 2'b10, 64'h99, 8'hFF, 2, resp, b);
    n_checks++;
    if ({resp, b} !== {2'b10, 4'd9}) $display("FAIL badwrap_bresp got=%0h/%0h required=2/9", resp, b); else n_pass++;
    do_write(4'd9, 32'h100, 8'd0, 2'b11, 64'h98, 8'hFF, 0, resp, b);
    n_checks++;
    if (resp !== 2'b10) $display("FAIL rsvd_write_bresp got=%0h required=2", resp); else n_pass++;
    do_read(1'b0, 4'd0, 32'h100, 8'd1, 2'b01);
    n_checks++;
    if ({rd_d[0], rd_d[1]} !== {64'd1, 64'd2})
      $display("FAIL suppressed_write d0=%0h d1=%0h required=1/2", rd_d[0], rd_d[1]);
    else n_pass++;
    do_write(4'd4, 32'h300, 8'd1, 2'b01, 64'h50, 8'hFF, 0, resp, b);
    n_checks++;
    if (resp !== 2'b10) $display("FAIL wlast_early_bresp got=%0h required=2", resp); else n_pass++;
    do_write(4'd4, 32'h7FF8, 8'd1, 2'b01, 64'hA0, 8'hFF, 0, resp, b);
    n_checks++;
    if (resp !== 2'b11) $display("FAIL wlast_decerr_bresp got=%0h required=3", resp); else n_pass++;
  endtask

  task automatic test_rdlat3_hold();
    int n;
    rsel = 1'b1; arid = 4'd9; araddr = 32'h100; arlen = 8'd1; arburst = 2'b01; rready = 1'b0; arvalid_in = 1'b1;
    n = 0;
    while (!m_arready && n < 50) begin @(posedge aclk); #1; n++; end
    @(posedge aclk); #1;
    arvalid_in = 1'b0;
    n = 1;
    while (!m_rvalid && n < 20) begin @(posedge aclk); #1; n++; end
    n_checks++;
    if (n !== 3) $display("FAIL hold_latency got=%0d required=3", n); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({m_rvalid, m_rlast, m_rresp, m_rdata} !== {1'b1, 1'b0, 2'b00, 64'd1})
        $display("FAIL hold_cycle%0d rvalid=%0b rlast=%0b rresp=%0h rdata=%0h required=1/0/0/1", c, m_rvalid, m_rlast, m_rresp, m_rdata);
      else n_pass++;
      @(posedge aclk); #1;
    end
    rready = 1'b1;
    n_checks++;
    if ({m_rvalid, m_rdata, m_rid} !== {1'b1, 64'd1, 4'd9})
      $display("FAIL hold_release rvalid=%0b rdata=%0h rid=%0d required=1/1/9", m_rvalid, m_rdata, m_rid);
    else n_pass++;
    @(posedge aclk); #1;
    n_checks++;
    if ({m_rvalid, m_rlast, m_rdata} !== {1'b1, 1'b1, 64'd2})
      $display("FAIL hold_beat2 rvalid=%0b rlast=%0b rdata=%0h required=1/1/2", m_rvalid, m_rlast, m_rdata);
    else n_pass++;
    @(posedge aclk); #1;
    n_checks++;
    if (m_rvalid !== 1'b0) $display("FAIL hold_done rvalid=%0b required=0", m_rvalid); else n_pass++;
    $display("read dut=1 id=9 addr=0x100 len=1 held rready low 5 cycles");
    rsel = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int n;
    logic b_seen;
    logic [1:0] resp; logic [IW-1:0] b;
    b_seen = 1'b0;
    bready = 1'b1;
    awid = 4'd6; awaddr = 32'h400; awlen = 8'd3; awburst = 2'b01; awvalid = 1'b1;
    n = 0;
    while (!awready0 && n < 50) begin @(posedge aclk); #1; n++; end
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wdata = 64'h10 + 64'(i); wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
      n = 0;
      while (!wready0 && n < 50) begin @(posedge aclk); #1; n++; end
      @(posedge aclk); #1;
      b_seen = b_seen | bvalid0;
    end
    wvalid = 1'b0;
    areset = 1'b1;
    @(posedge aclk); #1;
    b_seen = b_seen | bvalid0;
    areset = 1'b0;
    @(posedge aclk); #1;
    n_checks++;
    if (awready0 !== 1'b1) $display("FAIL midreset_awready got=%0b required=1", awready0); else n_pass++;
    for (int c = 0; c < 8; c++) begin
      b_seen = b_seen | bvalid0;
      @(posedge aclk); #1;
    end
    n_checks++;
    if (b_seen !== 1'b0) $display("FAIL midreset_bvalid seen=%0b required=0", b_seen); else n_pass++;
    bready = 1'b0;
    $display("write id=6 addr=0x400 len=3 abandoned by reset after 2 beats");
    do_write(4'd8, 32'h410, 8'd0, 2'b01, 64'h77, 8'hFF, 0, resp, b);
    n_checks++;
    if ({resp, b} !== {2'b00, 4'd8}) $display("FAIL postreset_bresp got=%0h/%0h required=0/8", resp, b); else n_pass++;
    do_read(1'b0, 4'd3, 32'h400, 8'd2, 2'b01);
    n_checks++;
    if ({rd_d[0], rd_d[1], rd_d[2]} !== {64'h10, 64'h11, 64'h77})
      $display("FAIL postreset_mem d0=%0h d1=%0h d2=%0h required=10/11/77", rd_d[0], rd_d[1], rd_d[2]);
    else n_pass++;
  endtask

  initial begin
    areset = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid_in = 1'b0; rready = 1'b0; rsel = 1'b0;
    test_reset();
    test_incr();
    test_wrap();
    test_strobe();
    test_errors();
    test_rdlat3_hold();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
